// File: rtl/port_rx.sv
// rtl/port_rx.sv - TIS-100 node port receiver (blocking read of UP/DOWN/LEFT/RIGHT/ANY/LAST/NIL); LAST support via PORT_RX_LAST_EN
module port_rx #(
    parameter int WORD_W = 11
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [3:0]            nbr_valid,
    input  logic [4*WORD_W-1:0]   nbr_data,
    output logic [3:0]            nbr_ack,
    input  logic                  rd_req,
    input  logic [2:0]            rd_sel,
    output logic                  rd_valid,
    output logic [WORD_W-1:0]     rd_data,
    output logic                  busy,
    output logic [1:0]            last_dir
);

    localparam logic [2:0] SEL_ANY = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    logic [2:0]          sel_q;

    logic [WORD_W-1:0]   nbr_word [4];
    logic [2:0]          cur_sel;
    logic                req_live;
    logic                resolved;
    logic                has_port;
    logic [1:0]          res_port;
    logic [WORD_W-1:0]   res_word;
    logic                capture;

`ifdef PORT_RX_LAST_EN
    logic [1:0]          last_dir_q;
    logic                last_vld;
`endif

    // Split the flat neighbour data bus into one word per direction
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nbr_word[i] = nbr_data[i*WORD_W +: WORD_W];
        end
    end

    // Resolve the selected source; in IDLE the fresh rd_sel is used so a ready port is acked in the request cycle
    always_comb begin
        cur_sel  = (state == IDLE) ? rd_sel : sel_q;
        req_live = nRST && (((state == IDLE) && rd_req) || (state == WAIT));
        resolved = 1'b1;
        has_port = 1'b0;
        res_port = 2'd0;
        case (cur_sel)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                has_port = 1'b1;
                res_port = cur_sel[1:0];
                resolved = nbr_valid[cur_sel[1:0]];
            end
            SEL_ANY: begin
                has_port = 1'b1;
                resolved = |nbr_valid;
                if (nbr_valid[2])      res_port = 2'd2;
                else if (nbr_valid[3]) res_port = 2'd3;
                else if (nbr_valid[0]) res_port = 2'd0;
                else                   res_port = 2'd1;
            end
`ifdef PORT_RX_LAST_EN
            3'd5: begin
                // With no ANY history LAST degrades to NIL
                if (last_vld) begin
                    has_port = 1'b1;
                    res_port = last_dir_q;
                    resolved = nbr_valid[last_dir_q];
                end
            end
`endif
            default: begin
                // NIL and code 7 resolve immediately with a zero word
            end
        endcase
        res_word = has_port ? nbr_word[res_port] : '0;
        capture  = req_live && resolved;
        nbr_ack  = (capture && has_port) ? (4'b0001 << res_port) : 4'b0000;
    end

    // Request FSM with registered response strobe and data
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            sel_q    <= 3'd0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
`ifdef PORT_RX_LAST_EN
            last_dir_q <= 2'd0;
            last_vld   <= 1'b0;
`endif
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        sel_q <= rd_sel;
                        state <= resolved ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (resolved) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (capture) begin
                rd_valid <= 1'b1;
                rd_data  <= res_word;
`ifdef PORT_RX_LAST_EN
                if (cur_sel == SEL_ANY) begin
                    last_dir_q <= res_port;
                    last_vld   <= 1'b1;
                end
`endif
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef PORT_RX_LAST_EN
    assign last_dir = last_dir_q;
`else
    assign last_dir = 2'd0;
`endif

endmodule
